fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Byte-serial transmitter draining the read side of a fifo16x8 buffer. When the FIFO is non-empty and the block is enabled, it pops one byte, then emits it on a single line as an 8N1 asynchronous serial frame (start bit, 8 data bits LSB first, stop bit). It sits between the FIFO's read port and the board-level TX pin and is the FIFO's only reader.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535
- clock_in  input  1  system clock; all state changes on rising edge
- reset_in  input  1  asynchronous, active-high reset
- enable_in  input  1  permits starting new frames; a frame in progress always completes
- fifo_empty_in  input  1  FIFO empty flag (empty_out of fifo16x8)
- fifo_rdata_in  input  8  FIFO read data; valid the cycle after a read pulse
- fifo_read_out  output  1  one-cycle pop request to the FIFO (read_in)
- tx_out  output  1  serial line; idles high
- busy_out  output  1  high whenever the block is not in IDLE

## Operation
- States: IDLE, READ, WAIT, START, DATA, STOP.
- IDLE: tx_out=1. If enable_in=1 and fifo_empty_in=0 at an edge → READ.
- READ (1 cycle): fifo_read_out=1 → WAIT.
- WAIT (1 cycle): fifo_read_out=0; at the exit edge, fifo_rdata_in loads the 8-bit shift register → START.
- START: tx_out=0 for CLKS_PER_BIT cycles → DATA.
- DATA: tx_out = shift[0]; every CLKS_PER_BIT cycles, shift right and increment bit index 0..7; after bit 7 → STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles → IDLE.
- fifo_read_out is asserted only in READ, so never while fifo_empty_in=1 was sampled.
- Bit timer is a down counter of width clog2(CLKS_PER_BIT), reloaded to CLKS_PER_BIT-1 on every state entry and at every bit boundary. Bit index is 3 bits and does not wrap past 7.
- enable_in is sampled only in IDLE. Dropping it mid-frame does not truncate the frame.
- A byte is consumed from the FIFO when READ occurs. If reset arrives after READ, that byte is lost. This is accepted behaviour.

## Timing
- Reset values: tx_out=1, fifo_read_out=0, busy_out=0, state IDLE, counters 0. Outputs take these values asynchronously on reset_in rise.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: the edge sampling non-empty in IDLE is edge E0.
  - fifo_read_out is high from E0 to E1.
  - tx_out falls at E3.
- Frame length is 10×CLKS_PER_BIT cycles from the tx_out fall to the end of the stop bit.
- Back-to-back frames have 3 extra high cycles between the stop bit end and the next start bit (IDLE, READ, WAIT).
- busy_out rises at E0 and falls at the edge that ends STOP.
- Simultaneous FIFO write while in IDLE with empty=1: no pop until empty=0 is sampled.
- reset_in deasserted: the first possible READ is at the first edge after release.

## Structure
- Package fifo_uart_pkg:
  - state enum (3 bits)
  - START_BIT=1'b0, STOP_BIT=1'b1, DATA_BITS=8
  - elaboration check: CLKS_PER_BIT ≥ 2
- Sub-module uart_bit_timer (counter, reload, tick output) parameterised by CLKS_PER_BIT. Instantiate it once; FSM and shift register stay in fifo_uart_tx.

## Test plan
Bench uses a real fifo16x8 instance with CLKS_PER_BIT=4.
- Reset:
  - Stimulus: reset_in high, then empty held 20 cycles after release.
  - Required: tx_out=1, busy_out=0, zero fifo_read_out pulses.
- Single byte:
  - Stimulus: write 0xAA.
  - Required: one read pulse; tx_out=0 for 4 cycles, then data 0,1,0,1,0,1,0,1 at 4 cycles each, then stop 1. Total 40 cycles; FIFO empty afterwards.
- Burst:
  - Stimulus: write 0x00..0x0F, which fills the FIFO (full=1).
  - Required: 16 frames decoded in order 0x00..0x0F; exactly 16 read pulses; 3-cycle gap between frames; empty=1 at the end.
- Enable gating:
  - Stimulus: 0x55 and 0x33 queued; drop enable_in during bit 2 of 0x55.
  - Required: the 0x55 frame completes; no read pulse for 20 cycles; after re-enabling, 0x33 is sent.
- Reset mid-frame:
  - Stimulus: assert reset_in during data bit 3 of 0xC3.
  - Required: tx_out=1 and busy_out=0 in the same time step. After release, the next queued byte transmits cleanly; 0xC3 is not resent.
- Pattern edges:
  - Stimulus: 0x00 then 0xFF.
  - Required: 0x00 gives 36 low cycles then the stop bit; 0xFF gives only the 4-cycle start bit low.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Contents: transmitter state encoding, 8N1 framing constants and a
// helper that validates the bit-period parameter at elaboration time.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  localparam logic       START_BIT        = 1'b0;
  localparam logic       STOP_BIT         = 1'b1;
  localparam int         DATA_BITS        = 8;
  localparam logic [2:0] LAST_BIT         = 3'(DATA_BITS - 1);
  localparam int         MIN_CLKS_PER_BIT = 2;
  localparam int         MAX_CLKS_PER_BIT = 65535;

  // True when the requested bit period is usable by the bit timer.
  function automatic bit clks_per_bit_ok(input int clks);
    return (clks >= MIN_CLKS_PER_BIT) && (clks <= MAX_CLKS_PER_BIT);
  endfunction

endpackage

// File: rtl/fifo16x8.sv
// 16-entry x 8-bit synchronous FIFO feeding the UART transmitter.
// Ports:
//   clock_in   system clock
//   reset_in   asynchronous active-high reset (pointers and count)
//   write_in   push wdata_in when not full
//   wdata_in   write data
//   read_in    pop when not empty; rdata_out valid the following cycle
//   rdata_out  registered read data
//   empty_out  no entries stored
//   full_out   16 entries stored
module fifo16x8 (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       write_in,
  input  logic [7:0] wdata_in,
  input  logic       read_in,
  output logic [7:0] rdata_out,
  output logic       empty_out,
  output logic       full_out
);

  logic [7:0] mem_r [0:15];
  logic [3:0] wptr_r;
  logic [3:0] rptr_r;
  logic [4:0] count_r;
  logic [7:0] rdata_r;
  logic       do_write_s;
  logic       do_read_s;

  assign do_write_s = write_in && (count_r != 5'd16);
  assign do_read_s  = read_in && (count_r != 5'd0);

  // Storage array write port.
  always_ff @(posedge clock_in) begin
    if (do_write_s) begin
      mem_r[wptr_r] <= wdata_in;
    end
  end

  // Pointers, occupancy count and registered read data.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      wptr_r  <= 4'd0;
      rptr_r  <= 4'd0;
      count_r <= 5'd0;
      rdata_r <= 8'd0;
    end else begin
      if (do_write_s) begin
        wptr_r <= wptr_r + 4'd1;
      end
      if (do_read_s) begin
        rptr_r  <= rptr_r + 4'd1;
        rdata_r <= mem_r[rptr_r];
      end
      case ({do_write_s, do_read_s})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata_out = rdata_r;
  assign empty_out = (count_r == 5'd0);
  assign full_out  = (count_r == 5'd16);

endmodule

// File: rtl/uart_bit_timer.sv
// Bit-period down counter for the UART transmitter.
// Ports:
//   clock_in  system clock
//   reset_in  asynchronous active-high reset (count cleared to 0)
//   reload    restart the period (count := CLKS_PER_BIT-1)
//   tick      high in the last cycle of the current bit period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic reload,
  output logic tick
);

  localparam int            CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD_VAL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ZERO       = CW'(0);
  localparam logic [CW-1:0] ONE        = CW'(1);

  logic [CW-1:0] count_r;

  // Down counter; free-runs through zero back to the reload value.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      count_r <= ZERO;
    end else if (reload) begin
      count_r <= RELOAD_VAL;
    end else if (count_r != ZERO) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= RELOAD_VAL;
    end
  end

  assign tick = (count_r == ZERO);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 serial transmitter that drains the read side of a fifo16x8.
// Ports:
//   clock_in       system clock
//   reset_in       asynchronous active-high reset
//   enable_in      allows new frames to start (sampled in IDLE only)
//   fifo_empty_in  FIFO empty flag
//   fifo_rdata_in  FIFO read data, valid the cycle after a pop
//   fifo_read_out  one-cycle pop request
//   tx_out         serial line, idles high
//   busy_out       high whenever a frame is being fetched or sent
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       enable_in,
  input  logic       fifo_empty_in,
  input  logic [7:0] fifo_rdata_in,
  output logic       fifo_read_out,
  output logic       tx_out,
  output logic       busy_out
);

  if (!clks_per_bit_ok(CLKS_PER_BIT)) begin : g_bad_clks_per_bit
    $error("fifo_uart_tx: CLKS_PER_BIT must be within 2..65535");
  end

  state_t     state_r;
  state_t     state_s;
  logic [7:0] shift_r;
  logic [2:0] bit_idx_r;
  logic       tick_s;
  logic       reload_s;
  logic       line_s;
  logic       tx_r;
  logic       read_r;
  logic       busy_r;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .reload  (reload_s),
    .tick    (tick_s)
  );

  // Next-state decode; the timer restarts on every state change and bit boundary.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable_in && !fifo_empty_in) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ:  state_s = ST_WAIT;
      ST_WAIT:  state_s = ST_START;
      ST_START: begin
        if (tick_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (bit_idx_r == LAST_BIT)) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    reload_s = (state_s != state_r) || tick_s;
  end

  // Line level for the current state; registered below, so the pin lags the
  // state by one cycle (start bit appears one edge after entering START).
  always_comb begin
    line_s = STOP_BIT;
    case (state_r)
      ST_IDLE:  line_s = STOP_BIT;
      ST_READ:  line_s = STOP_BIT;
      ST_WAIT:  line_s = STOP_BIT;
      ST_START: line_s = START_BIT;
      ST_DATA:  line_s = shift_r[0];
      ST_STOP:  line_s = STOP_BIT;
      default:  line_s = STOP_BIT;
    endcase
  end

  // State register.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shift register and bit index: load the popped byte in WAIT, shift LSB-first in DATA.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      shift_r   <= 8'd0;
      bit_idx_r <= 3'd0;
    end else if (state_r == ST_WAIT) begin
      shift_r   <= fifo_rdata_in;
      bit_idx_r <= 3'd0;
    end else if ((state_r == ST_DATA) && tick_s) begin
      shift_r <= {1'b0, shift_r[7:1]};
      if (bit_idx_r != LAST_BIT) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end else begin
        bit_idx_r <= bit_idx_r;
      end
    end else begin
      shift_r   <= shift_r;
      bit_idx_r <= bit_idx_r;
    end
  end

  // Registered outputs; pop and busy are decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      tx_r   <= STOP_BIT;
      read_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= line_s;
      read_r <= (state_s == ST_READ);
      busy_r <= (state_s != ST_IDLE);
    end
  end

  assign tx_out        = tx_r;
  assign fifo_read_out = read_r;
  assign busy_out      = busy_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int CPB        = 4;
  localparam int FRAME      = 10 * CPB;
  localparam int B2B_PERIOD = 43;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_rst = 1'b1;
  logic       enable = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'd0;
  logic       fifo_read;
  logic       tx;
  logic       busy;
  logic       empty;
  logic       full;
  logic [7:0] rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  logic [7:0] model_q[$];
  bit         active = 1'b0;
  int         fc = 0;
  logic [7:0] fbyte = 8'd0;
  bit         burst_mode = 1'b0;
  int         burst_prev = -1;
  logic       exp_tx;
  logic       exp_busy;
  logic [39:0] cap;
  int          p0;

  always #5 clk = ~clk;

  fifo16x8 u_fifo (
    .clock_in (clk),
    .reset_in (fifo_rst),
    .write_in (wr),
    .wdata_in (wdata),
    .read_in  (fifo_read),
    .rdata_out(rdata),
    .empty_out(empty),
    .full_out (full)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock_in     (clk),
    .reset_in     (rst),
    .enable_in    (enable),
    .fifo_empty_in(empty),
    .fifo_rdata_in(rdata),
    .fifo_read_out(fifo_read),
    .tx_out       (tx),
    .busy_out     (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected line level k cycles after the pop pulse was seen for byte b.
  function automatic logic exp_line(input int k, input logic [7:0] b);
    int idx;
    if (k < 3 || k >= 3 + FRAME) return 1'b1;
    idx = (k - 3) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // Model compare: every cycle, check tx/busy against the frame implied by the last pop.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      if (rst) begin
        active = 1'b0;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_read", fifo_read, 1'b0);
      end else begin
        if (fifo_read === 1'b1) begin
          pulses = pulses + 1;
          if (model_q.size() == 0) begin
            chk("read_while_empty", 1'b1, 1'b0);
          end else if (active && (cyc - fc) < FRAME + 3) begin
            chk("read_overlap_k", cyc - fc, FRAME + 3);
          end else begin
            fbyte  = model_q.pop_front();
            fc     = cyc;
            active = 1'b1;
          end
          if (burst_mode) begin
            if (burst_prev >= 0) chk("b2b_period", cyc - burst_prev, B2B_PERIOD);
            burst_prev = cyc;
          end
        end
        exp_tx   = active ? exp_line(cyc - fc, fbyte) : 1'b1;
        exp_busy = active && ((cyc - fc) <= FRAME + 1);
        chk("tx_line", tx, exp_tx);
        chk("busy", busy, exp_busy);
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    wr = 1'b1;
    wdata = b;
    model_q.push_back(b);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_fall(output bit ok);
    int n = 0;
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (tx === 1'b0);
    if (!ok) chk("fall_timeout", n, 0);
  endtask

  task automatic capture(input int drop_at, output logic [39:0] c);
    bit ok;
    c = '1;
    wait_fall(ok);
    if (ok) begin
      c[0] = tx;
      for (int i = 1; i < 40; i++) begin
        @(negedge clk);
        if (i == drop_at) enable = 1'b0;
        c[i] = tx;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((model_q.size() != 0 || busy !== 1'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk("idle_timeout", n, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, then 20 idle cycles with an empty FIFO.
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_read", fifo_read, 1'b0);
    rst = 1'b0;
    fifo_rst = 1'b0;
    enable = 1'b1;
    repeat (20) @(negedge clk);
    chk("reset_no_pulse", pulses, 0);
    chk("reset_empty", empty, 1'b1);

    // Single byte 0xAA.
    p0 = pulses;
    write_byte(8'hAA);
    capture(-1, cap);
    chk("aa_frame", cap, 40'hFF0F0F0F00);
    @(negedge clk);
    chk("aa_idle_after", tx, 1'b1);
    chk("aa_pulses", pulses - p0, 1);
    chk("aa_empty", empty, 1'b1);
    wait_idle(100);

    // Burst of 16 bytes filling the FIFO.
    enable = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    @(negedge clk);
    chk("burst_full", full, 1'b1);
    burst_prev = -1;
    burst_mode = 1'b1;
    p0 = pulses;
    enable = 1'b1;
    capture(-1, cap);
    chk("burst_first_frame", cap, 40'hF000000000);
    wait_idle(16 * B2B_PERIOD + 50);
    burst_mode = 1'b0;
    chk("burst_pulses", pulses - p0, 16);
    chk("burst_empty", empty, 1'b1);

    // Enable gating: drop enable during bit 2 of 0x55.
    write_byte(8'h55);
    write_byte(8'h33);
    capture(13, cap);
    chk("gate_55_frame", cap, 40'hF0F0F0F0F0);
    p0 = pulses;
    repeat (20) @(negedge clk);
    chk("gate_no_pulse", pulses - p0, 0);
    chk("gate_busy_low", busy, 1'b0);
    enable = 1'b1;
    capture(-1, cap);
    chk("gate_33_frame", cap, 40'hF00FF00FF0);
    wait_idle(100);

    // Reset during data bit 3 of 0xC3; 0x5A must follow, 0xC3 never resent.
    begin
      bit ok;
      write_byte(8'hC3);
      write_byte(8'h5A);
      wait_fall(ok);
      repeat (18) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_tx", tx, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("midrst_first_read", fifo_read, 1'b1);
      capture(-1, cap);
      chk("midrst_5a_frame", cap, 40'hF0F0FF0F00);
      wait_idle(100);
      repeat (20) @(negedge clk);
      chk("midrst_no_resend", busy, 1'b0);
      chk("midrst_empty", empty, 1'b1);
    end

    // Pattern edges: all-zero and all-one bytes.
    write_byte(8'h00);
    write_byte(8'hFF);
    capture(-1, cap);
    chk("edge_00_frame", cap, 40'hF000000000);
    capture(-1, cap);
    chk("edge_ff_frame", cap, 40'hFFFFFFFFF0);
    wait_idle(100);
    chk("edge_empty", empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
